data_unpacker: RTL and testbench
================================

Name: data_unpacker

Overview:
Read-side counterpart of the line packer on the DDR path. It fetches wide DDR words (default 512 bit) from a read FIFO filled by the DDR read master. It splits each wide word into narrow words (default 32 bit) and streams them out with a valid/ready handshake, line by line, for a programmed line length and line count per frame. It sits between the DDR read FIFO and the downstream Bayer/video pipeline.

Parameters:
g_DDR_AXI_DWIDTH_I, 512, width of a wide word read from the FIFO; must be an integer multiple of g_DDR_AXI_DWIDTH_O.
g_DDR_AXI_DWIDTH_O, 32, width of a narrow output word.
Derived lanes per wide word: L = g_DDR_AXI_DWIDTH_I / g_DDR_AXI_DWIDTH_O (16 at defaults); lane counter width = clog2(L).

Ports:
sys_clk_i  input  1  system clock; all logic on the rising edge.
rstn_i  input  1  asynchronous active-low reset.
frame_start_i  input  1  one-cycle pulse that starts a frame; sampled only in IDLE.
h_count_i  input  16  narrow words per line; latched at frame start.
v_count_i  input  16  lines per frame; latched at frame start.
fifo_empty_i  input  1  read FIFO empty.
fifo_rd_en_o  output  1  one-cycle FIFO read strobe.
fifo_data_i  input  g_DDR_AXI_DWIDTH_I  FIFO read data, valid exactly 1 cycle after fifo_rd_en_o.
data_o  output  g_DDR_AXI_DWIDTH_O  narrow output word.
data_valid_o  output  1  data_o valid.
ready_i  input  1  downstream accepts data_o when high together with data_valid_o.
line_end_o  output  1  one-cycle pulse after the last word of each line is accepted.
frame_done_o  output  1  one-cycle pulse after the last line of the frame completes.
busy_o  output  1  high in every state except IDLE.

Behaviour:
- Reset: all outputs 0, FSM in IDLE, counters 0, shift register 0. Reset is effective at any time, including mid-frame; after release, no rd_en and no data until the next frame_start_i.
- States: IDLE, FETCH, LOAD, SHIFT, LINE_END, DONE.
- IDLE: on frame_start_i, latch h_count_i and v_count_i. If either value is 0, go to DONE (frame_done_o pulses; no reads). Otherwise go to FETCH.
- frame_start_i outside IDLE is ignored.
- FETCH: wait while fifo_empty_i=1. When fifo_empty_i=0, assert fifo_rd_en_o for exactly one cycle and go to LOAD. fifo_rd_en_o is never asserted while fifo_empty_i=1.
- LOAD: capture fifo_data_i into the shift register, clear the lane counter, go to SHIFT.
- SHIFT: data_valid_o=1 and data_o = shift register bits [O-1:0].
  - While ready_i=0, data_o and data_valid_o hold stable.
  - On acceptance (data_valid_o & ready_i): shift the register right by O bits, increment the lane counter, increment the line word counter.
  - Lane order: lane 0 = fifo_data_i[O-1:0] is emitted first, lane L-1 last. This matches the LSB-first layout produced by the packer.
- SHIFT exit on acceptance:
  - line word count reaches h_count → LINE_END. Remaining lanes of the current wide word are discarded; each line starts on a fresh wide word.
  - else lane counter reaches L-1 → FETCH.
  - else stay in SHIFT.
- LINE_END: line_end_o=1 for one cycle; clear the line word counter; increment the line counter. If line count = v_count → DONE, else → FETCH.
- DONE: frame_done_o=1 for one cycle, then IDLE.
- Throughput: one narrow word per cycle within a wide word; 2-cycle bubble (FETCH+LOAD) per wide word when the FIFO is non-empty.
- Latency: frame_start_i to first data_valid_o = 3 cycles with a non-empty FIFO (IDLE→FETCH→LOAD→SHIFT).
- Wide words read per line = ceil(h_count / L). The line word counter is 16 bit and never wraps because it is compared against h_count ≤ 65535.
- data_valid_o is registered and low in all states except SHIFT.

Test Plan:
- h=32, v=2, FIFO holds 4 words with incrementing lanes, ready_i=1 → 4 rd_en pulses, 64 words in order with lane 0 first, line_end_o pulses after words 32 and 64, frame_done_o after the second line_end_o, busy_o low afterwards.
- h=20, v=1 → 2 reads; 20 words = 16 lanes of word 0 plus lanes 0..3 of word 1; lanes 4..15 of word 1 never appear; then line_end_o and frame_done_o.
- h=16, v=1, ready_i toggling 1-0-0-1 → data_o stable while ready_i=0; exactly 16 accepted words; no duplicates or drops.
- fifo_empty_i=1 for 10 cycles in FETCH → no rd_en, data_valid_o=0; first data appears 2 cycles after fifo_empty_i falls.
- h=0 or v=0 → no rd_en; frame_done_o pulses 2 cycles after frame_start_i.
- rstn_i low mid-line, then frame_start_i pulse while busy → reset clears all outputs; the pulse while busy is ignored; a new frame after reset restarts at lane 0, line 0.

Source files
------------

// File: rtl/data_unpacker_if.sv
// Handshake and bus bundle between the DDR read FIFO, the unpacker and the
// downstream video pipeline.
interface data_unpacker_if #(
  parameter int g_DDR_AXI_DWIDTH_I = 512,
  parameter int g_DDR_AXI_DWIDTH_O = 32
);
  logic                          frame_start_i;
  logic [15:0]                   h_count_i;
  logic [15:0]                   v_count_i;
  logic                          fifo_empty_i;
  logic                          fifo_rd_en_o;
  logic [g_DDR_AXI_DWIDTH_I-1:0] fifo_data_i;
  logic [g_DDR_AXI_DWIDTH_O-1:0] data_o;
  logic                          data_valid_o;
  logic                          ready_i;
  logic                          line_end_o;
  logic                          frame_done_o;
  logic                          busy_o;

  modport slave (
    input  frame_start_i, h_count_i, v_count_i, fifo_empty_i, fifo_data_i, ready_i,
    output fifo_rd_en_o, data_o, data_valid_o, line_end_o, frame_done_o, busy_o
  );

  modport master (
    output frame_start_i, h_count_i, v_count_i, fifo_empty_i, fifo_data_i, ready_i,
    input  fifo_rd_en_o, data_o, data_valid_o, line_end_o, frame_done_o, busy_o
  );
endinterface

// File: rtl/data_unpacker.sv
// Splits wide DDR words from the read FIFO into narrow words, LSB lane first,
// and streams them line by line for a programmed line length and line count.
module data_unpacker #(
  parameter int g_DDR_AXI_DWIDTH_I = 512,
  parameter int g_DDR_AXI_DWIDTH_O = 32
) (
  input  logic           sys_clk_i,
  input  logic           rstn_i,
  data_unpacker_if.slave bus
);
  localparam int L      = g_DDR_AXI_DWIDTH_I / g_DDR_AXI_DWIDTH_O;
  localparam int LANE_W = (L > 1) ? $clog2(L) : 1;
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(L - 1);

  if (g_DDR_AXI_DWIDTH_I % g_DDR_AXI_DWIDTH_O != 0) begin : g_width_check
    $error("data_unpacker: input width must be a multiple of output width");
  end

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    FETCH    = 3'd1,
    LOAD     = 3'd2,
    SHIFT    = 3'd3,
    LINE_END = 3'd4,
    DONE     = 3'd5
  } state_t;

  state_t state, next_state;

  logic [g_DDR_AXI_DWIDTH_I-1:0] lanes_p0;
  logic [LANE_W-1:0]             lane_cnt;
  logic [15:0]                   word_cnt;
  logic [15:0]                   line_cnt;
  logic [15:0]                   h_len;
  logic [15:0]                   v_len;

  logic accept;
  logic line_full;
  logic frame_full;
  logic zero_size;

  logic rd_en;
  logic valid_nxt;
  logic line_end_nxt;
  logic frame_done_nxt;
  logic data_valid;
  logic line_end;
  logic frame_done;

  assign accept     = (state == SHIFT) && bus.ready_i;
  // 17-bit compares so the +1 can never alias back onto a small count.
  assign line_full  = ({1'b0, word_cnt} + 17'd1) == {1'b0, h_len};
  assign frame_full = ({1'b0, line_cnt} + 17'd1) == {1'b0, v_len};
  assign zero_size  = (bus.h_count_i == 16'd0) || (bus.v_count_i == 16'd0);

  // State register
  always_ff @(posedge sys_clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (bus.frame_start_i) begin
          next_state = zero_size ? DONE : FETCH;
        end
      end
      FETCH: begin
        if (!bus.fifo_empty_i) begin
          next_state = LOAD;
        end
      end
      LOAD: begin
        next_state = SHIFT;
      end
      SHIFT: begin
        // A finished line always wins: leftover lanes are dropped so the
        // next line starts on a fresh wide word.
        if (accept) begin
          if (line_full) begin
            next_state = LINE_END;
          end else if (lane_cnt == LAST_LANE) begin
            next_state = FETCH;
          end
        end
      end
      LINE_END: begin
        next_state = frame_full ? DONE : FETCH;
      end
      DONE: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Output decode
  always_comb begin
    rd_en          = 1'b0;
    valid_nxt      = 1'b0;
    line_end_nxt   = 1'b0;
    frame_done_nxt = 1'b0;
    rd_en          = (state == FETCH) && !bus.fifo_empty_i;
    valid_nxt      = (next_state == SHIFT);
    line_end_nxt   = (state == LINE_END);
    frame_done_nxt = (state == DONE);
  end

  always_ff @(posedge sys_clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      data_valid <= 1'b0;
      line_end   <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      data_valid <= valid_nxt;
      line_end   <= line_end_nxt;
      frame_done <= frame_done_nxt;
    end
  end

  // Stage p0: wide-word shift register and frame counters
  always_ff @(posedge sys_clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      lanes_p0 <= '0;
      lane_cnt <= '0;
      word_cnt <= '0;
      line_cnt <= '0;
      h_len    <= '0;
      v_len    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.frame_start_i) begin
            h_len    <= bus.h_count_i;
            v_len    <= bus.v_count_i;
            word_cnt <= '0;
            line_cnt <= '0;
            lane_cnt <= '0;
          end
        end
        LOAD: begin
          lanes_p0 <= bus.fifo_data_i;
          lane_cnt <= '0;
        end
        SHIFT: begin
          if (accept) begin
            lanes_p0 <= lanes_p0 >> g_DDR_AXI_DWIDTH_O;
            lane_cnt <= lane_cnt + LANE_W'(1);
            word_cnt <= word_cnt + 16'd1;
          end
        end
        LINE_END: begin
          word_cnt <= '0;
          line_cnt <= line_cnt + 16'd1;
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.fifo_rd_en_o = rd_en;
  assign bus.data_o       = lanes_p0[g_DDR_AXI_DWIDTH_O-1:0];
  assign bus.data_valid_o = data_valid;
  assign bus.line_end_o   = line_end;
  assign bus.frame_done_o = frame_done;
  assign bus.busy_o       = (state != IDLE);

endmodule

// File: tb/tb_data_unpacker.sv
// Bench for data_unpacker: FIFO model, table of frames checked against a
// lane-order reference, plus latency, stall and reset sequences.
module tb_data_unpacker;
  localparam int I = 512;
  localparam int O = 32;
  localparam int L = I / O;

  logic clk;
  logic rstn;

  data_unpacker_if #(.g_DDR_AXI_DWIDTH_I(I), .g_DDR_AXI_DWIDTH_O(O)) bus ();

  data_unpacker #(.g_DDR_AXI_DWIDTH_I(I), .g_DDR_AXI_DWIDTH_O(O)) dut (
    .sys_clk_i (clk),
    .rstn_i    (rstn),
    .bus       (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    int h;
    int v;
    int rmode;
    int stall;
    int inject;
    int incr;
    int reads;
    int words;
    int lines;
  } row_t;

  row_t rows[9];

  logic [I-1:0] fifo_q[$];
  logic [I-1:0] wide_q[$];
  logic [O-1:0] exp_q[$];
  logic [O-1:0] got_q[$];
  int           le_marks[$];

  int n_checks, n_fail, cyc, cur_row, cur_h;
  int rd_cnt, done_cnt, done_cyc, last_le_cyc, first_valid_cyc, start_cyc;
  int ready_mode, k_cyc;
  bit stall, inject, force_empty, start_req, prev_valid, prev_ready;
  logic [O-1:0] prev_data;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s (frame %0d): got %0h, required %0h", name, cur_row, act, req);
    end
  endtask

  function automatic logic [I-1:0] make_word(input int n, input bit incr);
    logic [I-1:0] w;
    w = '0;
    for (int k = 0; k < L; k++) begin
      w[k*O +: O] = incr ? O'(n * L + k) : O'($urandom);
    end
    return w;
  endfunction

  // One clock: drive inputs on the falling edge, sample 1 time unit later.
  task automatic cycle();
    @(negedge clk);
    cyc++;
    bus.frame_start_i = start_req || (inject && bus.busy_o && ($urandom_range(0, 3) == 0));
    if (inject && bus.busy_o) begin
      bus.h_count_i = 16'($urandom);
      bus.v_count_i = 16'($urandom);
    end
    start_req = 1'b0;
    bus.fifo_empty_i = (stall ? ($urandom_range(0, 9) < 3) : force_empty) || (fifo_q.size() == 0);
    case (ready_mode)
      0:       bus.ready_i = 1'b1;
      1:       bus.ready_i = (cyc % 4 == 0) || (cyc % 4 == 3);
      default: bus.ready_i = 1'($urandom_range(0, 1));
    endcase
    #1;
    if (bus.fifo_rd_en_o) begin
      rd_cnt++;
      check("rd_en_while_empty", bus.fifo_empty_i, 0);
      if (fifo_q.size() > 0) bus.fifo_data_i = fifo_q.pop_front();
    end
    if (prev_valid && !prev_ready) begin
      check("hold_valid", bus.data_valid_o, 1);
      check("hold_data", bus.data_o, prev_data);
    end
    if (bus.data_valid_o && first_valid_cyc < 0) first_valid_cyc = cyc;
    if (bus.data_valid_o && bus.ready_i) got_q.push_back(bus.data_o);
    if (bus.line_end_o) begin
      le_marks.push_back(got_q.size());
      last_le_cyc = cyc;
    end
    if (bus.frame_done_o) begin
      done_cnt++;
      done_cyc = cyc;
    end
    prev_valid = bus.data_valid_o;
    prev_ready = bus.ready_i;
    prev_data  = bus.data_o;
  endtask

  task automatic clear_stats();
    got_q.delete();
    le_marks.delete();
    rd_cnt = 0;
    done_cnt = 0;
    done_cyc = -1;
    last_le_cyc = -1;
    first_valid_cyc = -1;
  endtask

  // Reference: each line consumes ceil(h/L) fresh wide words, lane 0 first,
  // and keeps only its first h lanes.
  task automatic start_frame(input int h, input int v, input bit incr);
    int nr, per_line, idx;
    logic [I-1:0] w;
    per_line = (h + L - 1) / L;
    nr = (h == 0 || v == 0) ? 0 : v * per_line;
    wide_q.delete();
    exp_q.delete();
    clear_stats();
    for (int n = 0; n < nr; n++) begin
      w = make_word(n, incr);
      wide_q.push_back(w);
      fifo_q.push_back(w);
    end
    idx = 0;
    if (nr > 0) begin
      for (int ln = 0; ln < v; ln++) begin
        for (int r = 0; r < per_line; r++) begin
          w = wide_q[idx];
          idx++;
          for (int k = 0; k < L; k++) begin
            if (r * L + k < h) exp_q.push_back(w[k*O +: O]);
          end
        end
      end
    end
    cur_h = h;
    bus.h_count_i = 16'(h);
    bus.v_count_i = 16'(v);
    start_req = 1'b1;
    cycle();
    start_cyc = cyc;
  endtask

  task automatic finish_frame();
    for (int t = 0; t < 3000 && done_cnt == 0; t++) cycle();
    inject = 1'b0;
    repeat (3) cycle();
  endtask

  task automatic check_frame(input int reads, input int words, input int lines);
    int n;
    check("rd_en_count", rd_cnt, reads);
    check("accepted_words", got_q.size(), words);
    check("line_end_count", le_marks.size(), lines);
    check("frame_done_count", done_cnt, 1);
    check("busy_after_frame", bus.busy_o, 0);
    check("fifo_words_left", fifo_q.size(), 0);
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) check("word_value", got_q[i], exp_q[i]);
    for (int k = 0; k < le_marks.size(); k++) check("line_end_position", le_marks[k], cur_h * (k + 1));
    if (le_marks.size() > 0) check("done_after_line_end", done_cyc > last_le_cyc, 1);
    fifo_q.delete();
  endtask

  task automatic check_idle_outputs(input string name);
    check({name, "_rd_en"}, bus.fifo_rd_en_o, 0);
    check({name, "_data"}, bus.data_o, 0);
    check({name, "_valid"}, bus.data_valid_o, 0);
    check({name, "_line_end"}, bus.line_end_o, 0);
    check({name, "_frame_done"}, bus.frame_done_o, 0);
    check({name, "_busy"}, bus.busy_o, 0);
  endtask

  initial begin
    //          h   v  rm st inj inc reads words lines
    rows[0] = '{32, 2, 0, 0, 0, 1,  4,    64,   2};
    rows[1] = '{20, 1, 0, 0, 0, 0,  2,    20,   1};
    rows[2] = '{16, 1, 1, 0, 0, 0,  1,    16,   1};
    rows[3] = '{0,  3, 0, 0, 0, 0,  0,    0,    0};
    rows[4] = '{5,  0, 0, 0, 0, 0,  0,    0,    0};
    rows[5] = '{17, 3, 2, 0, 1, 0,  6,    51,   3};
    rows[6] = '{1,  4, 2, 1, 1, 0,  4,    4,    4};
    rows[7] = '{48, 1, 2, 1, 0, 0,  3,    48,   1};
    rows[8] = '{33, 2, 1, 1, 1, 0,  6,    66,   2};

    n_checks = 0; n_fail = 0; cyc = 0; cur_row = -1; cur_h = 0;
    ready_mode = 0; stall = 0; inject = 0; force_empty = 0; start_req = 0;
    prev_valid = 0; prev_ready = 0; prev_data = '0;
    clear_stats();
    rstn = 1'b0;
    bus.frame_start_i = 1'b0;
    bus.h_count_i = '0;
    bus.v_count_i = '0;
    bus.fifo_empty_i = 1'b1;
    bus.fifo_data_i = '0;
    bus.ready_i = 1'b0;

    repeat (3) @(negedge clk);
    #1;
    check_idle_outputs("reset_state");
    rstn = 1'b1;

    // Non-empty FIFO after reset release must not trigger reads.
    fifo_q.push_back(make_word(0, 0));
    repeat (5) cycle();
    check("no_read_before_start", rd_cnt, 0);
    check("no_valid_before_start", first_valid_cyc, -1);
    fifo_q.delete();

    for (int r = 0; r < 9; r++) begin
      cur_row = r;
      ready_mode = rows[r].rmode;
      stall = rows[r].stall[0];
      start_frame(rows[r].h, rows[r].v, rows[r].incr[0]);
      inject = rows[r].inject[0];
      finish_frame();
      check_frame(rows[r].reads, rows[r].words, rows[r].lines);
      stall = 0;
    end

    // Latency from frame_start to first valid with a ready FIFO.
    cur_row = 100;
    ready_mode = 0;
    start_frame(4, 1, 0);
    finish_frame();
    check("start_to_valid_latency", first_valid_cyc - start_cyc, 3);
    check_frame(1, 4, 1);

    // Empty frame: done two cycles after the start pulse.
    cur_row = 101;
    start_frame(0, 2, 0);
    finish_frame();
    check("zero_frame_done_latency", done_cyc - start_cyc, 2);
    check_frame(0, 0, 0);

    // FIFO held empty for 10 cycles while fetching.
    cur_row = 102;
    force_empty = 1'b1;
    start_frame(16, 1, 1);
    repeat (10) cycle();
    check("stall_no_read", rd_cnt, 0);
    check("stall_no_valid", first_valid_cyc, -1);
    check("stall_busy", bus.busy_o, 1);
    force_empty = 1'b0;
    cycle();
    k_cyc = cyc;
    finish_frame();
    check("empty_fall_to_valid", first_valid_cyc - k_cyc, 2);
    check_frame(1, 16, 1);

    // Reset mid-line, with an ignored start pulse while busy beforehand.
    cur_row = 103;
    ready_mode = 0;
    start_frame(32, 1, 0);
    for (int t = 0; t < 100 && got_q.size() < 5; t++) cycle();
    start_req = 1'b1;
    cycle();
    check("busy_mid_line", bus.busy_o, 1);
    @(negedge clk);
    rstn = 1'b0;
    #1;
    check_idle_outputs("reset_mid_line");
    repeat (2) cycle();
    rstn = 1'b1;
    fifo_q.delete();
    bus.fifo_data_i = '0;
    fifo_q.push_back(make_word(7, 0));
    clear_stats();
    prev_valid = 1'b0;
    repeat (6) cycle();
    check("no_read_after_reset", rd_cnt, 0);
    check("no_valid_after_reset", first_valid_cyc, -1);
    fifo_q.delete();
    start_frame(16, 1, 1);
    finish_frame();
    check("restart_latency", first_valid_cyc - start_cyc, 3);
    check_frame(1, 16, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running, required finished");
    $fatal(1, "timeout");
  end
endmodule
